// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results (priority) and buffered multiply results into one register-file write port.
// Optional overflow trap enabled by defining WB_OVF_TRAP_EN.
module wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int REG_SIZE = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  input  logic [REG_SIZE-1:0] alu_result,
  input  logic [4:0]          alu_dst,
  input  logic                mul_valid,
  input  logic [REG_SIZE-1:0] mul_result,
  input  logic                mul_zero,
  input  logic                mul_overflow,
  input  logic [4:0]          mul_dst,
  output logic                mul_stall,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [REG_SIZE-1:0] rf_wdata,
  output logic                rf_zero,
  output logic                exc_overflow,
  output logic [31:0]         pending_mask
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
`ifdef WB_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [REG_SIZE-1:0] buf_data [DEPTH];
  logic [4:0]          buf_dst  [DEPTH];
  logic                buf_zero [DEPTH];
  logic                buf_ovf  [DEPTH];
  logic                buf_live [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;

  logic accept, kill, bypass, deq, enq, in_live;
  logic                sel_we, sel_zero, sel_exc;
  logic [4:0]          sel_addr;
  logic [REG_SIZE-1:0] sel_data;

  assign mul_stall = (count == CW'(DEPTH));
  assign accept    = mul_valid && !mul_stall;
  assign kill      = alu_valid && (alu_dst != 5'd0);
  // An accepted result that finds the slot free and the buffer empty skips storage.
  assign bypass    = accept && (count == '0) && !alu_valid;
  assign deq       = !alu_valid && (count != '0);
  assign enq       = accept && !bypass;
  assign in_live   = !(kill && (mul_dst == alu_dst));

  always_comb begin
    sel_we   = 1'b0;
    sel_zero = 1'b0;
    sel_exc  = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (alu_valid) begin
      sel_we   = (alu_dst != 5'd0);
      sel_addr = alu_dst;
      sel_data = alu_result;
      sel_zero = (alu_result == '0);
    end else if (deq) begin
      sel_we   = buf_live[rd_ptr] && (buf_dst[rd_ptr] != 5'd0) && !(TRAP_EN && buf_ovf[rd_ptr]);
      sel_exc  = buf_live[rd_ptr] && TRAP_EN && buf_ovf[rd_ptr];
      sel_addr = buf_dst[rd_ptr];
      sel_data = buf_data[rd_ptr];
      sel_zero = buf_zero[rd_ptr];
    end else if (bypass) begin
      sel_we   = (mul_dst != 5'd0) && !(TRAP_EN && mul_overflow);
      sel_exc  = TRAP_EN && mul_overflow;
      sel_addr = mul_dst;
      sel_data = mul_result;
      sel_zero = mul_zero;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      rf_zero      <= 1'b0;
      exc_overflow <= 1'b0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      for (int i = 0; i < DEPTH; i++) buf_live[i] <= 1'b0;
    end else begin
      rf_we        <= sel_we;
      rf_waddr     <= sel_addr;
      rf_wdata     <= sel_data;
      rf_zero      <= sel_zero;
      exc_overflow <= sel_exc;
      // A newer ALU write to the same register makes buffered results stale.
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && (buf_dst[i] == alu_dst)) buf_live[i] <= 1'b0;
      end
      if (enq) begin
        buf_live[wr_ptr] <= in_live;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      buf_data[wr_ptr] <= mul_result;
      buf_dst[wr_ptr]  <= mul_dst;
      buf_zero[wr_ptr] <= mul_zero;
      buf_ovf[wr_ptr]  <= mul_overflow;
    end
  end

  always_comb begin
    logic [PW-1:0] off;
    off          = '0;
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (({1'b0, off} < count) && buf_live[i] && (buf_dst[i] != 5'd0))
        pending_mask[buf_dst[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes queued at drive time, popped whenever rf_we is seen.
module tb_wb_arbiter;

  logic        clk, reset;
  logic        alu_valid, mul_valid, mul_zero, mul_overflow;
  logic [31:0] alu_result, mul_result;
  logic [4:0]  alu_dst, mul_dst;
  logic        mul_stall, rf_we, rf_zero, exc_overflow;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pending_mask;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        zero;
  } wr_t;

  wr_t sb[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  logic exp_exc = 1'b0;

  wb_arbiter #(.DEPTH(4), .REG_SIZE(32)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_result(alu_result), .alu_dst(alu_dst),
    .mul_valid(mul_valid), .mul_result(mul_result), .mul_zero(mul_zero),
    .mul_overflow(mul_overflow), .mul_dst(mul_dst), .mul_stall(mul_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_zero(rf_zero),
    .exc_overflow(exc_overflow), .pending_mask(pending_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d, input logic z);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.zero = z;
    sb.push_back(e);
  endtask

  task automatic idle();
    alu_valid = 0; alu_result = '0; alu_dst = '0;
    mul_valid = 0; mul_result = '0; mul_dst = '0; mul_zero = 0; mul_overflow = 0;
  endtask

  task automatic drive_alu(input logic [4:0] d, input logic [31:0] r);
    alu_valid = 1; alu_dst = d; alu_result = r;
  endtask

  task automatic drive_mul(input logic [4:0] d, input logic [31:0] r, input logic z, input logic o);
    mul_valid = 1; mul_dst = d; mul_result = r; mul_zero = z; mul_overflow = o;
  endtask

  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    if (rf_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {59'd0, rf_waddr}, 64'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("waddr", rf_waddr, e.addr);
        chk("wdata", rf_wdata, e.data);
        chk("rf_zero", rf_zero, e.zero);
      end
    end
    chk("exc_overflow", exc_overflow, exp_exc);
  endtask

  initial begin
    reset = 1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_zero", rf_zero, 0);
    chk("rst_exc", exc_overflow, 0);
    chk("rst_stall", mul_stall, 0);
    chk("rst_mask", pending_mask, 0);
    reset = 0;
    step(); step();

    // ALU only, then ALU writing zero
    drive_alu(5, 32'h12); push_wr(5, 32'h12, 0);
    step();
    chk("alu_we", rf_we, 1);
    drive_alu(6, 32'h0); push_wr(6, 32'h0, 1);
    step();
    chk("alu_zero_we", rf_we, 1);
    idle();
    step();
    chk("alu_idle_we", rf_we, 0);

    // ALU / multiply conflict
    drive_alu(3, 32'h33); drive_mul(7, 32'hAA, 0, 0);
    push_wr(3, 32'h33, 0); push_wr(7, 32'hAA, 0);
    step();
    chk("conf_mask_c1", pending_mask, 32'h80);
    idle();
    step();
    chk("conf_we_c2", rf_we, 1);
    chk("conf_mask_c2", pending_mask, 0);
    step();
    chk("conf_we_c3", rf_we, 0);

    // Bypass with zero flag, and a discarded dst=0 bypass
    drive_mul(12, 32'h0, 1, 0); push_wr(12, 32'h0, 1);
    step();
    chk("byp_we", rf_we, 1);
    chk("byp_mask", pending_mask, 0);
    drive_mul(0, 32'h77, 0, 0);
    step();
    chk("dst0_we", rf_we, 0);
    idle();
    step();

    // Fill to full while ALU holds the slot, then drain
    drive_alu(1, 32'h100);
    for (int i = 0; i < 4; i++) begin
      drive_mul(5'(8 + i), 32'h800 + 32'(i), 0, 0);
      push_wr(1, 32'h100, 0);
      step();
    end
    chk("fill_stall", mul_stall, 1);
    drive_mul(13, 32'hD00, 0, 0);
    push_wr(1, 32'h100, 0);
    step();
    chk("full_hold_stall", mul_stall, 1);
    chk("full_mask", pending_mask, 32'h0000_0F00);
    alu_valid = 0;
    for (int i = 0; i < 4; i++) push_wr(5'(8 + i), 32'h800 + 32'(i), 0);
    push_wr(13, 32'hD00, 0);
    step();
    chk("drain_r8_we", rf_we, 1);
    chk("drain_stall", mul_stall, 0);
    chk("drain_mask", pending_mask, 32'h0000_0E00);
    step();
    idle();
    repeat (3) step();
    chk("drain_sb_empty", sb.size(), 0);
    step();
    chk("drain_done_we", rf_we, 0);
    chk("drain_done_mask", pending_mask, 0);

    // Kill of a buffered entry
    drive_alu(1, 32'h7); drive_mul(9, 32'h99, 0, 0); push_wr(1, 32'h7, 0);
    step();
    chk("kill_mask_pre", pending_mask, 32'h200);
    idle();
    drive_alu(9, 32'h55); push_wr(9, 32'h55, 0);
    step();
    chk("kill_mask_post", pending_mask, 0);
    idle();
    step();
    chk("kill_dead_deq_we", rf_we, 0);
    step();

    // Kill of the same-cycle incoming entry
    drive_alu(10, 32'hA); drive_mul(10, 32'hBAD, 0, 0); push_wr(10, 32'hA, 0);
    step();
    chk("kill_in_mask", pending_mask, 0);
    idle();
    step();
    chk("kill_in_we", rf_we, 0);

    // Overflow on a bypassed result
    drive_mul(4, 32'h44, 0, 1);
`ifdef WB_OVF_TRAP_EN
    exp_exc = 1;
    step();
    exp_exc = 0;
    chk("ovf_we", rf_we, 0);
    idle();
    step();
`else
    push_wr(4, 32'h44, 0);
    step();
    chk("ovf_we", rf_we, 1);
    idle();
    step();
`endif

    // Reset with three buffered entries
    drive_alu(1, 32'h11);
    for (int i = 0; i < 3; i++) begin
      drive_mul(5'(20 + i), 32'h2000 + 32'(i), 0, 0);
      push_wr(1, 32'h11, 0);
      step();
    end
    chk("pre_rst_mask", pending_mask, 32'h0070_0000);
    reset = 1;
    idle();
    #1;
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_mask", pending_mask, 0);
    chk("mid_rst_stall", mul_stall, 0);
    @(posedge clk);
    #1;
    reset = 0;
    repeat (3) step();
    chk("post_rst_we", rf_we, 0);
    chk("post_rst_mask", pending_mask, 0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
